// File: rtl/tt_proc_host_link_pkg.sv
// Shared types and constants for the host-side
// tt_um_processor pin shims.
package tt_proc_host_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_HI,
    S_GAP_W,
    S_SEND_LO,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  localparam logic [7:0] ERR_DATA = 8'hFF;

  // bit positions on the processor's uio bus
  localparam int STROBE_BIT = 0;
  localparam int DONE_BIT   = 0;

endpackage

// File: rtl/tt_proc_host_link_if.sv
// Command, response and processor-pin bundle
// for tt_proc_host_link.
interface tt_proc_host_link_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [7:0]  pin_data_o;
  logic        pin_strobe_o;
  logic [7:0]  pin_result_i;
  logic        pin_done_i;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_data,
    input  pin_result_i, pin_done_i,
    input  rsp_ready,
    output cmd_ready,
    output pin_data_o, pin_strobe_o,
    output rsp_valid, rsp_data, rsp_err,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_data,
    output pin_result_i, pin_done_i,
    output rsp_ready,
    input  cmd_ready,
    input  pin_data_o, pin_strobe_o,
    input  rsp_valid, rsp_data, rsp_err,
    input  busy
  );

endinterface

// File: rtl/tt_proc_host_link_timer.sv
// Clearable up-counter that flags the last cycle
// of a TIMEOUT-cycle window; TIMEOUT=0 never expires.
module tt_proc_host_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W =
    (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST =
    W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/tt_proc_host_link.sv
// Host shim: sends a 16-bit command to tt_um_processor
// as two strobed bytes and returns the 8-bit result.
module tt_proc_host_link
  import tt_proc_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 1
) (
  input logic               clk,
  input logic               rst_n,
  tt_proc_host_link_if.master bus
);

  localparam logic [3:0] GAP_LAST =
    (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     state, state_d;
  logic [7:0] cmd_lo, cmd_lo_d;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic [7:0] data_d, rdata_d;
  logic       strobe_d, rvalid_d, rerr_d;
  logic       tmr_clr, tmr_en, tmr_exp;

  tt_proc_host_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .expire(tmr_exp)
  );

  always_comb begin
    state_d   = state;
    cmd_lo_d  = cmd_lo;
    gap_cnt_d = gap_cnt;
    data_d    = bus.pin_data_o;
    strobe_d  = 1'b0;
    rvalid_d  = bus.rsp_valid;
    rdata_d   = bus.rsp_data;
    rerr_d    = bus.rsp_err;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d  = S_SEND_HI;
          cmd_lo_d = bus.cmd_data[7:0];
          data_d   = bus.cmd_data[15:8];
          strobe_d = 1'b1;
        end
      end
      S_SEND_HI: begin
        gap_cnt_d = GAP_LAST;
        if (GAP == 0) begin
          state_d  = S_SEND_LO;
          data_d   = cmd_lo;
          strobe_d = 1'b1;
        end else begin
          state_d = S_GAP_W;
        end
      end
      S_GAP_W: begin
        if (gap_cnt == 4'd0) begin
          state_d  = S_SEND_LO;
          data_d   = cmd_lo;
          strobe_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt - 4'd1;
        end
      end
      S_SEND_LO: begin
        state_d = S_WAIT_DONE;
        tmr_clr = 1'b1;
      end
      S_WAIT_DONE: begin
        // done is checked first so it wins a tie with expiry
        if (bus.pin_done_i) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = bus.pin_result_i;
          rerr_d   = 1'b0;
        end else if (tmr_exp) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = ERR_DATA;
          rerr_d   = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d  = S_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cmd_lo           <= '0;
      gap_cnt          <= '0;
      bus.pin_data_o   <= '0;
      bus.pin_strobe_o <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_err      <= 1'b0;
    end else begin
      state            <= state_d;
      cmd_lo           <= cmd_lo_d;
      gap_cnt          <= gap_cnt_d;
      bus.pin_data_o   <= data_d;
      bus.pin_strobe_o <= strobe_d;
      bus.rsp_valid    <= rvalid_d;
      bus.rsp_data     <= rdata_d;
      bus.rsp_err      <= rerr_d;
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_tt_proc_host_link.sv
// Bench for tt_proc_host_link: GAP=0 and GAP=1 instances
// share input streams and are checked cycle by cycle.
module tb_tt_proc_host_link;
  import tt_proc_host_pkg::*;

  localparam int N  = 160;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cv_i;
  logic [15:0] cd_i;
  logic        done_i;
  logic [7:0]  res_i;
  logic        rr_i;

  tt_proc_host_link_if bus0 ();
  tt_proc_host_link_if bus1 ();

  assign bus0.cmd_valid    = cv_i;
  assign bus0.cmd_data     = cd_i;
  assign bus0.pin_done_i   = done_i;
  assign bus0.pin_result_i = res_i;
  assign bus0.rsp_ready    = rr_i;
  assign bus1.cmd_valid    = cv_i;
  assign bus1.cmd_data     = cd_i;
  assign bus1.pin_done_i   = done_i;
  assign bus1.pin_result_i = res_i;
  assign bus1.rsp_ready    = rr_i;

  tt_proc_host_link #(.TIMEOUT(TO), .GAP(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  tt_proc_host_link #(.TIMEOUT(TO), .GAP(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  bit          s_cv   [N];
  logic [15:0] s_cd   [N];
  bit          s_done [N];
  logic [7:0]  s_res  [N];
  bit          s_rr   [N];

  // {busy, ready, err, rsp_valid, strobe, rsp_data, pin_data}
  logic [20:0] e_vec [2][N];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] obs(input int g);
    if (g == 0)
      return {bus0.busy, bus0.cmd_ready, bus0.rsp_err,
              bus0.rsp_valid, bus0.pin_strobe_o,
              bus0.rsp_data, bus0.pin_data_o};
    return {bus1.busy, bus1.cmd_ready, bus1.rsp_err,
            bus1.rsp_valid, bus1.pin_strobe_o,
            bus1.rsp_data, bus1.pin_data_o};
  endfunction

  task automatic put(input int g, input int c,
                     input logic [7:0] d, input bit stb,
                     input bit rv, input logic [7:0] rd,
                     input bit er, input bit bz);
    if (c < N) e_vec[g][c] = {bz, ~bz, er, rv, stb, rd, d};
  endtask

  // Transaction-level schedule: accept at a, high byte at a+1,
  // low byte at a+2+gap, wait window from a+3+gap.
  task automatic build(input int g, input int gap);
    logic [7:0] d;
    logic [7:0] rd;
    bit er;
    bit fin;
    int c;
    int a;
    int w;
    d = 8'h00;
    rd = 8'h00;
    er = 1'b0;
    c = 0;
    while (c < N) begin
      put(g, c, d, 1'b0, 1'b0, rd, er, 1'b0);
      if (!s_cv[c]) begin
        c++;
        continue;
      end
      a = c;
      d = s_cd[a][15:8];
      put(g, a + 1, d, 1'b1, 1'b0, rd, er, 1'b1);
      for (int k = 1; k <= gap; k++)
        put(g, a + 1 + k, d, 1'b0, 1'b0, rd, er, 1'b1);
      d = s_cd[a][7:0];
      put(g, a + 2 + gap, d, 1'b1, 1'b0, rd, er, 1'b1);
      w = a + 3 + gap;
      c = w;
      fin = 1'b0;
      while (c < N && !fin) begin
        put(g, c, d, 1'b0, 1'b0, rd, er, 1'b1);
        if (s_done[c]) begin
          rd = s_res[c];
          er = 1'b0;
          fin = 1'b1;
        end else if (c - w == TO - 1) begin
          rd = ERR_DATA;
          er = 1'b1;
          fin = 1'b1;
        end
        c++;
      end
      fin = 1'b0;
      while (c < N && !fin) begin
        put(g, c, d, 1'b0, 1'b1, rd, er, 1'b1);
        fin = s_rr[c];
        c++;
      end
    end
  endtask

  task automatic clr_streams();
    for (int c = 0; c < N; c++) begin
      s_cv[c] = 1'b0;
      s_cd[c] = 16'h0000;
      s_done[c] = 1'b0;
      s_res[c] = 8'h00;
      s_rr[c] = 1'b1;
    end
  endtask

  task automatic check_cycle(input string name, input int c);
    logic [20:0] o;
    logic [20:0] e;
    string p;
    for (int g = 0; g < 2; g++) begin
      o = obs(g);
      e = e_vec[g][c];
      p = $sformatf("%s g%0d c%0d", name, g, c);
      chk({p, " pin_data"}, o[7:0], e[7:0]);
      chk({p, " rsp_data"}, o[15:8], e[15:8]);
      chk({p, " strobe"}, 8'(o[16]), 8'(e[16]));
      chk({p, " rsp_valid"}, 8'(o[17]), 8'(e[17]));
      chk({p, " rsp_err"}, 8'(o[18]), 8'(e[18]));
      chk({p, " cmd_ready"}, 8'(o[19]), 8'(e[19]));
      chk({p, " busy"}, 8'(o[20]), 8'(e[20]));
    end
  endtask

  task automatic run_ep(input string name);
    build(0, 0);
    build(1, 1);
    cv_i = 1'b0;
    cd_i = 16'h0000;
    done_i = 1'b0;
    res_i = 8'h00;
    rr_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) begin
      check_cycle(name, c);
      cv_i = s_cv[c];
      cd_i = s_cd[c];
      done_i = s_done[c];
      res_i = s_res[c];
      rr_i = s_rr[c];
      @(negedge clk);
    end
  endtask

  initial begin
    logic [20:0] o;
    cv_i = 1'b0;
    cd_i = 16'h0000;
    done_i = 1'b0;
    res_i = 8'h00;
    rr_i = 1'b0;

    clr_streams();
    s_cv[0] = 1'b1;
    s_cd[0] = 16'hA53C;
    s_done[6] = 1'b1;
    s_res[6] = 8'h5A;
    run_ep("basic");

    clr_streams();
    s_cv[0] = 1'b1;
    s_cd[0] = 16'h1234;
    run_ep("timeout");

    clr_streams();
    s_cv[0] = 1'b1;
    s_cd[0] = 16'hC0DE;
    s_done[11] = 1'b1;
    s_res[11] = 8'h11;
    run_ep("tie");

    clr_streams();
    for (int c = 0; c < N; c++) begin
      s_cv[c] = 1'b1;
      s_cd[c] = 16'($urandom);
      s_done[c] = 1'b1;
      s_res[c] = 8'(c + 3);
      s_rr[c] = (c >= 12);
    end
    run_ep("stall");

    for (int r = 0; r < 6; r++) begin
      clr_streams();
      for (int c = 0; c < N; c++) begin
        s_cv[c] = ($urandom_range(0, 1) == 1);
        s_cd[c] = 16'($urandom);
        s_done[c] = ($urandom_range(0, 7) == 0);
        s_res[c] = 8'($urandom);
        s_rr[c] = ($urandom_range(0, 2) != 0);
      end
      run_ep($sformatf("rand%0d", r));
    end

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cv_i = 1'b1;
    cd_i = 16'hBEEF;
    done_i = 1'b0;
    rr_i = 1'b0;
    @(negedge clk);
    cv_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      o = obs(g);
      chk($sformatf("midrst g%0d busy_before", g),
          8'(o[20]), 8'h01);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      o = obs(g);
      chk($sformatf("midrst g%0d strobe", g), 8'(o[16]), 8'h00);
      chk($sformatf("midrst g%0d rsp_valid", g), 8'(o[17]), 8'h00);
      chk($sformatf("midrst g%0d busy", g), 8'(o[20]), 8'h00);
      chk($sformatf("midrst g%0d pin_data", g), o[7:0], 8'h00);
    end

    clr_streams();
    s_cv[0] = 1'b1;
    s_cd[0] = 16'h0102;
    s_done[8] = 1'b1;
    s_res[8] = 8'h77;
    run_ep("after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
